// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
// Holds the FSM state encoding, grant-side encoding and parameter defaults.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I-side, D-side, arbiter and backing memory.
// slave: arbiter view. master: requester/memory environment view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_ready;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic                m_ack;
  logic [DATA_W-1:0]   m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ready, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_ack, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ready, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_ack, m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Grant decision plus saturating starvation counter for the I-side.
// Ports: clk, rst (sync, active-low), idle, d_req, i_req -> grant_d, grant_i.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic d_req,
  input  logic i_req,
  output logic grant_d,
  output logic grant_i
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  // D wins unless I has waited through SMAX D grants
  assign grant_d = idle & d_req &
                   (~i_req | (starve_cnt < SMAX));
  assign grant_i = idle & i_req & ~grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!i_req)
        starve_cnt <= '0;
      else if (starve_cnt != 4'hf)
        starve_cnt <= starve_cnt + 4'd1;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between I-fetch and D-side load/store.
// Ports: clk, rst (sync, active-low), bus (slave modport), busy, err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              err
);

  localparam int         BE_W      = DATA_W / 8;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t state;
  state_t state_n;
  gnt_t   side;

  logic grant_d;
  logic grant_i;
  logic timeout;

  logic [7:0] wait_cnt;

  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [BE_W-1:0]   m_be_q;

  logic              i_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              err_q;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .idle   (state == IDLE),
    .d_req  (bus.d_req),
    .i_req  (bus.i_req),
    .grant_d(grant_d),
    .grant_i(grant_i)
  );

  assign side    = (state == D_ACC) ? GNT_D : GNT_I;
  assign timeout = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_n = D_ACC;
        else if (grant_i) state_n = I_ACC;
      end
      I_ACC, D_ACC: begin
        if (bus.m_ack || timeout) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_d) begin
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            m_be_q    <= bus.d_be;
          end else if (grant_i) begin
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= bus.i_addr;
            m_wdata_q <= '0;
            m_be_q    <= '1;
          end
        end
        I_ACC, D_ACC: begin
          wait_cnt <= wait_cnt + 8'd1;
          // ack beats a coincident timeout
          if (bus.m_ack) begin
            m_req_q <= 1'b0;
            if (side == GNT_I) begin
              i_rdata_q <= bus.m_rdata;
              i_ready_q <= 1'b1;
            end else begin
              if (!m_we_q) d_rdata_q <= bus.m_rdata;
              d_ready_q <= 1'b1;
            end
          end else if (timeout) begin
            m_req_q <= 1'b0;
            err_q   <= 1'b1;
            if (side == GNT_I) begin
              i_rdata_q <= '0;
              i_ready_q <= 1'b1;
            end else begin
              d_rdata_q <= '0;
              d_ready_q <= 1'b1;
            end
          end
        end
        RESP: begin
          m_req_q <= 1'b0;
        end
        default: begin
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_be    = m_be_q;
  assign bus.i_ready = i_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.d_rdata = d_rdata_q;

  assign busy = (state != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Drives both requesters and plays the memory by hand.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic err;

  int n_cmp = 0;
  int n_bad = 0;

  int i_pulses = 0;
  int d_pulses = 0;
  int both_cnt = 0;
  int mreq_rises = 0;
  logic prev_mreq = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4),
    .TIMEOUT   (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy),
    .err (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    prev_mreq <= bus.m_req;
    if (bus.m_req && !prev_mreq) mreq_rises <= mreq_rises + 1;
    if (bus.i_ready) i_pulses <= i_pulses + 1;
    if (bus.d_ready) d_pulses <= d_pulses + 1;
    if (bus.i_ready && bus.d_ready) both_cnt <= both_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=hang req=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s obs=%h req=%h", tag, obs, req);
    end
  endtask

  task automatic ack_now(input logic [31:0] data);
    bus.m_ack   = 1'b1;
    bus.m_rdata = data;
    tick;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
  endtask

  initial begin
    logic [6:0] exp_i;
    int dk;
    int n;
    int r0;
    int p0;

    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;

    // reset state
    tick;
    tick;
    chk("rst_mreq", bus.m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_irdata", bus.i_rdata, 0);
    chk("rst_drdata", bus.d_rdata, 0);
    chk("rst_iready", bus.i_ready, 0);
    rst = 1'b1;
    tick;

    // single fetch
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    tick;
    chk("f_mreq", bus.m_req, 1);
    chk("f_maddr", bus.m_addr, 32'h100);
    chk("f_mwe", bus.m_we, 0);
    chk("f_mbe", bus.m_be, 32'hf);
    tick;
    tick;
    chk("f_mreq_held", bus.m_req, 1);
    ack_now(32'h00500093);
    chk("f_iready", bus.i_ready, 1);
    chk("f_irdata", bus.i_rdata, 32'h00500093);
    chk("f_mreq_drop", bus.m_req, 0);
    bus.i_req = 1'b0;
    tick;
    chk("f_iready_off", bus.i_ready, 0);
    chk("f_busy", busy, 0);
    chk("f_ipulses", i_pulses, 1);

    // simultaneous: D store first, then I
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'b0011;
    tick;
    chk("s_maddr_d", bus.m_addr, 32'h200);
    chk("s_mwe_d", bus.m_we, 1);
    chk("s_mbe_d", bus.m_be, 32'h3);
    chk("s_mwdata", bus.m_wdata, 32'hDEADBEEF);
    ack_now(32'h12345678);
    chk("s_dready", bus.d_ready, 1);
    chk("s_iready_lo", bus.i_ready, 0);
    chk("s_drdata_store", bus.d_rdata, 0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick;
    tick;
    chk("s_maddr_i", bus.m_addr, 32'h104);
    chk("s_mwe_i", bus.m_we, 0);
    ack_now(32'h00A00113);
    chk("s_iready", bus.i_ready, 1);
    chk("s_irdata", bus.i_rdata, 32'h00A00113);
    bus.i_req = 1'b0;
    tick;

    // starvation: grants D,D,D,D,I,D,D
    exp_i = 7'b0010000;
    dk = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h300;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h400;
    for (int g = 0; g < 7; g++) begin
      tick;
      chk($sformatf("starve_gnt%0d", g), bus.m_addr,
          exp_i[g] ? 32'h300 : 32'h400 + 32'(4 * dk));
      ack_now(32'hA000 + 32'(g));
      if (exp_i[g]) begin
        bus.i_req = 1'b0;
      end else begin
        dk++;
        if (dk == 6) bus.d_req = 1'b0;
        else         bus.d_addr = 32'h400 + 32'(4 * dk);
      end
      tick;
    end
    chk("starve_drdata", bus.d_rdata, 32'hA006);

    // timeout on a load
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h500;
    tick;
    chk("t_mreq", bus.m_req, 1);
    n = 0;
    while (!bus.d_ready && n < 100) begin
      tick;
      n++;
    end
    chk("t_latency", n, 64);
    chk("t_drdata", bus.d_rdata, 0);
    chk("t_err", err, 1);
    chk("t_mreq_drop", bus.m_req, 0);
    bus.d_req = 1'b0;
    tick;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h504;
    tick;
    ack_now(32'h0BADF00D);
    chk("t2_dready", bus.d_ready, 1);
    chk("t2_drdata", bus.d_rdata, 32'h0BADF00D);
    chk("t2_err_sticky", err, 1);
    bus.d_req = 1'b0;
    tick;

    // reset mid-access, then a late ack
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h600;
    tick;
    chk("r_mreq", bus.m_req, 1);
    p0 = d_pulses;
    rst = 1'b0;
    tick;
    chk("r_mreq_drop", bus.m_req, 0);
    chk("r_busy", busy, 0);
    chk("r_dready", bus.d_ready, 0);
    chk("r_err", err, 0);
    rst       = 1'b1;
    bus.d_req = 1'b0;
    bus.m_ack = 1'b1;
    bus.m_rdata = 32'hFFFF0000;
    tick;
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    chk("r_late_busy", busy, 0);
    chk("r_late_drdata", bus.d_rdata, 0);
    tick;
    chk("r_no_pulse", d_pulses - p0, 0);

    // ack coincident with the timeout cycle
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h604;
    tick;
    for (int k = 0; k < 63; k++) tick;
    chk("b_still_acc", bus.m_req, 1);
    ack_now(32'h55AA55AA);
    chk("b_dready", bus.d_ready, 1);
    chk("b_drdata", bus.d_rdata, 32'h55AA55AA);
    chk("b_err", err, 0);
    bus.d_req = 1'b0;
    tick;

    // request held through the ready cycle
    r0 = mreq_rises;
    p0 = i_pulses;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h700;
    tick;
    ack_now(32'h13);
    chk("h_iready", bus.i_ready, 1);
    tick;
    bus.i_req = 1'b0;
    tick;
    tick;
    chk("h_rises", mreq_rises - r0, 1);
    chk("h_pulses", i_pulses - p0, 1);
    chk("h_busy", busy, 0);
    chk("both_never", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch requester (I-side) and the load/store requester (D-side, MEM stage).
- Serialises accesses with a small FSM. D-side has priority, and a bounded-starvation counter protects the I-side.
- Registered valid/ready handshakes on both requester ports and the memory port. The D-side ready output drives the pipeline's existing D-memory ready signal.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, max consecutive D grants while i_req is pending before I is forced; range 1..15
- TIMEOUT, 64, max cycles to wait for m_ack before aborting with error; range 2..255

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- i_req  in  1  I-side request; held with i_addr stable until i_ready
- i_addr  in  ADDR_W  I-side word address
- i_ready  out  1  one-cycle completion pulse; i_rdata valid this cycle
- i_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  D-side request; held with all d_* fields stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  store data (already lane-aligned)
- d_be  in  DATA_W/8  store byte enables
- d_ready  out  1  one-cycle completion pulse; d_rdata valid for loads
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request; held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  DATA_W/8  memory byte enables
- m_ack  in  1  one-cycle memory acknowledge; m_rdata valid this cycle
- m_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
Reset (rst=0 at a rising edge):
- State goes to IDLE. All outputs go to 0, including rdata registers, starve_cnt, wait_cnt and err.
- Reset asserted mid-access drops m_req on the next edge and raises no ready pulse.
- The memory must tolerate an abandoned request.

States: IDLE, I_ACC, D_ACC, RESP.

IDLE:
- d_req=1 and (i_req=0 or starve_cnt<STARVE_MAX): go to D_ACC. Latch d_we, d_addr, d_wdata, d_be onto the m_* registers.
- Otherwise, if i_req=1: go to I_ACC. Latch i_addr; m_we=0; m_be all ones.
- m_req is registered high from the first cycle in an ACC state. Grant-to-m_req latency is 1 cycle.

I_ACC / D_ACC:
- m_req and all m_* fields are held constant.
- wait_cnt increments each cycle and is cleared on ACC entry.
- On m_ack=1: capture m_rdata into the granted side's rdata register (loads and fetches only; stores leave d_rdata unchanged). Go to RESP, drop m_req, and raise the granted side's ready at the next edge.
- If wait_cnt reaches TIMEOUT-1 without m_ack: set err, go to RESP, and return rdata = 0 with ready pulsed.
- m_ack arriving in the same cycle as the timeout counts as a normal completion; err stays clear.

RESP:
- Lasts exactly 1 cycle. The ready pulse is high only here.
- Requests are ignored here, so a requester whose req is still high in the ready cycle is not double-granted.
- Always returns to IDLE. Minimum access cost is 3 cycles plus memory latency; back-to-back grants are spaced by RESP + IDLE.

m_ack outside I_ACC / D_ACC is ignored.

starve_cnt:
- On a D grant with i_req=1: saturating increment.
- On a D grant with i_req=0: cleared.
- On an I grant: cleared.

Outputs:
- i_rdata and d_rdata hold their last captured value between pulses.
- Ready pulses are never asserted on both sides in the same cycle.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants IDLE=2'd0, I_ACC=2'd1, D_ACC=2'd2, RESP=2'd3;
  - default parameter values;
  - a grant-side encoding, GNT_I / GNT_D.
- One natural sub-module, arb_starve_ctr: the saturating starvation counter plus the grant-decision logic. It outputs grant_d and grant_i given d_req, i_req and an IDLE indicator.
- The FSM, m_* registers and wait counter remain in mem_port_arbiter.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_ack two cycles after m_req, m_rdata=0x00500093 -> m_req rises 1 cycle after i_req, m_addr=0x100, m_we=0; i_ready pulses once with i_rdata=0x00500093; busy low afterwards.
- Simultaneous requests: i_req and d_req both high in IDLE, store to 0x200 with d_wdata=0xDEADBEEF, d_be=4'b0011 -> D granted first with m_we=1, m_be=4'b0011; then I granted; d_ready precedes i_ready; never both in one cycle.
- Starvation: d_req held high continuously with 6 loads, i_req held high, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D.
- Timeout: d_req load with m_ack never asserted, TIMEOUT=64 -> d_ready pulses 64 cycles after m_req rises; d_rdata=0; err=1 and stays 1 through further successful accesses.
- Reset mid-access: rst=0 while in D_ACC with m_req=1 -> next edge m_req=0, busy=0, no d_ready pulse, err=0; a late m_ack one cycle later is ignored.
- Held request in RESP: requester keeps i_req=1 through the i_ready cycle and then drops it -> exactly one m_req transaction and one i_ready pulse.
